i2cmb_txn_sequencer: RTL and testbench
======================================

Name: i2cmb_txn_sequencer

Overview:
- Hardware command sequencer that drives the iicmb_m_wb Wishbone slave port as a Wishbone master.
- Accepts single-byte I2C read/write requests on a valid/ready request port and issues the full iicmb command sequence: Set Bus, Start, Address byte, Data byte, Stop.
- Uses the DUT irq to detect command completion and returns the status and read data on a response port.
- Sits between a local requester (or a test harness) and the DUT Wishbone port, in place of the wb master BFM.

Parameters:
- NUM_I2C_BUSSES, 16, number of I2C buses in the DUT; a request with bus id >= this value is still issued, and the DUT reports ERR.
- BUS_ID_WIDTH, 4, width of the request bus id.
- WB_ADDR_WIDTH, 2, Wishbone address width.
- WB_DATA_WIDTH, 8, Wishbone data width.
- IRQ_TIMEOUT, 65535, maximum number of cycles to wait for irq after each CMDR write.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; synchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  sequencer idle and initialised; request accepted on valid&&ready
- req_bus_i  in  BUS_ID_WIDTH  target I2C bus id
- req_addr_i  in  7  I2C slave address
- req_rw_i  in  1  0=write, 1=read
- req_wdata_i  in  8  write data byte
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_status_o  out  2  00 OK, 01 NAK, 10 ARB_LOST/ERR, 11 TIMEOUT
- rsp_rdata_o  out  8  read byte, valid with OK read
- busy_o  out  1  transaction in progress
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  WB_ADDR_WIDTH  register offset: CSR=0, DPR=1, CMDR=2, FSMR=3
- dat_o  out  WB_DATA_WIDTH  write data
- dat_i  in  WB_DATA_WIDTH  read data
- ack_i  in  1  Wishbone ack
- irq_i  in  1  DUT interrupt request

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - All outputs go to 0 at that edge; rsp_rdata_o=0x00.
  - The FSM returns to INIT; this applies mid-transaction as well.
  - No response is issued for an aborted request.
- Wishbone cycle:
  - Drive cyc=stb=1 with adr/we/dat; hold until ack_i is sampled high.
  - Deassert cyc/stb on the cycle after ack.
  - Insert a minimum of one idle cycle between Wishbone cycles.
  - No timeout on ack.
- INIT: write CSR=0xC0 (core enable, interrupt enable), then go to IDLE.
- IDLE:
  - req_ready_o=1 and busy_o=0.
  - On accept, latch all req_* fields, set busy_o=1, drop req_ready_o.
- Command step sequence:
  1. DPR<=bus
  2. CMDR<=0x06 (Set Bus)
  3. CMDR<=0x04 (Start)
  4. DPR<={addr,rw}
  5. CMDR<=0x01 (Write)
  6. Data phase:
     - write: DPR<=wdata, then CMDR<=0x01
     - read: CMDR<=0x03 (Read with NAK), then read DPR into rdata
  7. CMDR<=0x05 (Stop)
- After every CMDR write:
  - Enter WAIT_IRQ; a counter starts at 0.
  - When irq_i=1, perform a Wishbone read of CMDR (this clears the irq) and evaluate bits 7:4.
    - DON(7): continue to the next step.
    - NAK(6) on address or data write: status=NAK, jump to Stop.
    - AL(5) or ERR(4): status=ARB_LOST/ERR, skip Stop, go to RESP.
    - Precedence when several bits are set: AL/ERR > NAK > DON.
  - Counter reaches IRQ_TIMEOUT: status=TIMEOUT, write CSR=0x00 then CSR=0xC0, then go to RESP.
- The Stop completion does not overwrite an already-latched NAK status.
- RESP:
  - rsp_valid_o=1 for exactly one cycle.
  - rsp_status_o/rsp_rdata_o hold until the next response.
  - rsp_rdata_o updates only on an OK read.
  - Next cycle: IDLE, busy_o=0, req_ready_o=1.
- Latency: the earliest rsp_valid_o is 1 cycle after the Stop CMDR read completes; there is no request pipelining (one outstanding).
- irq already high on WAIT_IRQ entry: treated as completion immediately.

Test Plan:
- Reset release → one CSR write (adr=0, dat=0xC0, we=1) observed; then req_ready_o=1.
- Write req bus=2, addr=0x22, data=0xA5, slave ACKs → Wishbone writes in order DPR=0x02, CMDR=0x06, CMDR=0x04, DPR=0x44, CMDR=0x01, DPR=0xA5, CMDR=0x01, CMDR=0x05; I2C slave sees 0xA5; rsp status=00.
- Read req bus=0, addr=0x22, slave returns 0x5A → DPR=0x45 and CMDR=0x03 issued; rsp status=00, rdata=0x5A.
- Address NAK (no slave at 0x10) → Stop (CMDR=0x05) still issued; rsp status=01; rdata unchanged.
- irq suppressed after Start with IRQ_TIMEOUT=100 → rsp status=11 about 100 cycles after the Start write; CSR=0x00 then CSR=0xC0 written; next request completes OK.
- rst_n_i low during data phase → next edge cyc/stb/busy/rsp_valid=0; after release, INIT CSR write repeats; no response for the aborted request.

Source files
------------

// File: rtl/i2cmb_txn_sequencer.sv
// rtl/i2cmb_txn_sequencer.sv - single-byte I2C transaction sequencer mastering the iicmb Wishbone port
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   req_valid_i/req_ready_o   request handshake; req_bus_i, req_addr_i, req_rw_i, req_wdata_i
//   rsp_valid_o               one-cycle response pulse with rsp_status_o / rsp_rdata_o
//   busy_o                    transaction in progress
//   cyc_o/stb_o/we_o/adr_o/dat_o, dat_i, ack_i   Wishbone master
//   irq_i                     iicmb command-completion interrupt
module i2cmb_txn_sequencer #(
  parameter int NUM_I2C_BUSSES = 16,
  parameter int BUS_ID_WIDTH   = 4,
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int IRQ_TIMEOUT    = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [BUS_ID_WIDTH-1:0]  req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic                     req_rw_i,
  input  logic [7:0]               req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [1:0]               rsp_status_o,
  output logic [7:0]               rsp_rdata_o,
  output logic                     busy_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  // Out-of-range bus ids are passed through untouched (the core flags ERR),
  // but the id field must at least be wide enough to name every bus.
  if (NUM_I2C_BUSSES > (1 << BUS_ID_WIDTH)) begin : g_cfg_check
    $error("BUS_ID_WIDTH too narrow for NUM_I2C_BUSSES");
  end

  localparam int CNT_W = $clog2(IRQ_TIMEOUT + 1);

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

  localparam logic [1:0] ST_OK = 2'b00, ST_NAK = 2'b01, ST_ERR = 2'b10, ST_TO = 2'b11;

  // Step numbers double as the program counter of the command sequence;
  // steps 8/9 are the CSR disable/enable pair shared by init and timeout recovery.
  localparam logic [3:0] STEP_DPR_BUS  = 4'd0;
  localparam logic [3:0] STEP_SETBUS   = 4'd1;
  localparam logic [3:0] STEP_START    = 4'd2;
  localparam logic [3:0] STEP_DPR_ADDR = 4'd3;
  localparam logic [3:0] STEP_ADDR     = 4'd4;
  localparam logic [3:0] STEP_DATA0    = 4'd5;
  localparam logic [3:0] STEP_DATA1    = 4'd6;
  localparam logic [3:0] STEP_STOP     = 4'd7;
  localparam logic [3:0] STEP_CSR_OFF  = 4'd8;
  localparam logic [3:0] STEP_CSR_ON   = 4'd9;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_BUS, S_WAIT_IRQ, S_RESP} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               step_q, step_d;
  logic                     rd_cmdr_q, rd_cmdr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BUS_ID_WIDTH-1:0]  bus_q, bus_d;
  logic [6:0]               addr_q, addr_d;
  logic                     rw_q, rw_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     busy_q, busy_d;
  logic [1:0]               st_q, st_d;
  logic [7:0]               rbyte_q, rbyte_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [1:0]               rsp_status_q, rsp_status_d;
  logic [7:0]               rsp_rdata_q, rsp_rdata_d;

  logic                     op_we;
  logic [WB_ADDR_WIDTH-1:0] op_adr;
  logic [7:0]               op_dat;
  logic                     step_is_cmd;
  logic                     step_nak_matters;

  // Bus access issued for the current step.
  always_comb begin
    op_we  = 1'b1;
    op_adr = ADR_CMDR;
    op_dat = 8'h00;
    case (step_q)
      STEP_DPR_BUS:  begin op_adr = ADR_DPR; op_dat = 8'(bus_q); end
      STEP_SETBUS:   op_dat = 8'h06;
      STEP_START:    op_dat = 8'h04;
      STEP_DPR_ADDR: begin op_adr = ADR_DPR; op_dat = {addr_q, rw_q}; end
      STEP_ADDR:     op_dat = 8'h01;
      STEP_DATA0:    begin
        if (rw_q) op_dat = 8'h03;
        else begin op_adr = ADR_DPR; op_dat = wdata_q; end
      end
      STEP_DATA1:    begin
        if (rw_q) begin op_adr = ADR_DPR; op_we = 1'b0; end
        else op_dat = 8'h01;
      end
      STEP_STOP:     op_dat = 8'h05;
      STEP_CSR_OFF:  begin op_adr = ADR_CSR; op_dat = 8'h00; end
      STEP_CSR_ON:   begin op_adr = ADR_CSR; op_dat = 8'hC0; end
      default:       op_dat = 8'h00;
    endcase
  end

  assign step_is_cmd = (op_adr == ADR_CMDR) && op_we;
  assign step_nak_matters = (step_q == STEP_ADDR) || (step_q == STEP_DATA1 && !rw_q);

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    rd_cmdr_d    = rd_cmdr_q;
    cnt_d        = cnt_q;
    bus_d        = bus_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;
    st_d         = st_q;
    rbyte_d      = rbyte_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;

    case (state_q)
      S_INIT: begin
        step_d  = STEP_CSR_ON;
        state_d = S_ISSUE;
      end
      S_IDLE: begin
        if (req_valid_i) begin
          bus_d   = req_bus_i;
          addr_d  = req_addr_i;
          rw_d    = req_rw_i;
          wdata_d = req_wdata_i;
          busy_d  = 1'b1;
          st_d    = ST_OK;
          step_d  = STEP_DPR_BUS;
          state_d = S_ISSUE;
        end
      end
      // One cycle with cyc low before every access guarantees the idle gap.
      S_ISSUE: begin
        we_d      = op_we;
        adr_d     = op_adr;
        dat_d     = WB_DATA_WIDTH'(op_dat);
        rd_cmdr_d = 1'b0;
        state_d   = S_BUS;
      end
      S_BUS: begin
        if (ack_i) begin
          if (rd_cmdr_q) begin
            if (dat_i[5] || dat_i[4]) begin
              st_d    = ST_ERR;
              state_d = S_RESP;
            end else if (dat_i[6] && step_nak_matters) begin
              st_d    = ST_NAK;
              step_d  = STEP_STOP;
              state_d = S_ISSUE;
            end else if (step_q == STEP_STOP) begin
              state_d = S_RESP;
            end else begin
              step_d  = step_q + 4'd1;
              state_d = S_ISSUE;
            end
          end else if (step_is_cmd) begin
            cnt_d   = '0;
            state_d = S_WAIT_IRQ;
          end else if (step_q == STEP_DATA1) begin
            rbyte_d = dat_i[7:0];
            step_d  = STEP_STOP;
            state_d = S_ISSUE;
          end else if (step_q == STEP_CSR_ON) begin
            // Same CSR enable closes both power-up init and timeout recovery.
            state_d = busy_q ? S_RESP : S_IDLE;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          we_d      = 1'b0;
          adr_d     = ADR_CMDR;
          dat_d     = '0;
          rd_cmdr_d = 1'b1;
          state_d   = S_BUS;
        end else if (cnt_q == CNT_W'(IRQ_TIMEOUT)) begin
          st_d    = ST_TO;
          step_d  = STEP_CSR_OFF;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    if (state_d == S_RESP && state_q != S_RESP) begin
      rsp_status_d = st_d;
      if (st_d == ST_OK && rw_q) rsp_rdata_d = rbyte_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_INIT;
      step_q       <= '0;
      rd_cmdr_q    <= 1'b0;
      cnt_q        <= '0;
      bus_q        <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      st_q         <= ST_OK;
      rbyte_q      <= '0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_status_q <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      rd_cmdr_q    <= rd_cmdr_d;
      cnt_q        <= cnt_d;
      bus_q        <= bus_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      st_q         <= st_d;
      rbyte_q      <= rbyte_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_status_o = rsp_status_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign busy_o       = busy_q;
  assign cyc_o        = (state_q == S_BUS);
  assign stb_o        = (state_q == S_BUS);
  assign we_o         = we_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;

endmodule

// File: tb/tb_i2cmb_txn_sequencer.sv
// tb/tb_i2cmb_txn_sequencer.sv - self-checking bench for i2cmb_txn_sequencer
module tb_i2cmb_txn_sequencer;

  localparam int TO_CYC = 100;

  logic       clk, rst_n_i;
  logic       req_valid_i, req_ready_o, req_rw_i;
  logic [3:0] req_bus_i;
  logic [6:0] req_addr_i;
  logic [7:0] req_wdata_i;
  logic       rsp_valid_o, busy_o;
  logic [1:0] rsp_status_o;
  logic [7:0] rsp_rdata_o;
  logic       cyc_o, stb_o, we_o, ack_i, irq_i;
  logic [1:0] adr_o;
  logic [7:0] dat_o, dat_i;

  i2cmb_txn_sequencer #(
    .NUM_I2C_BUSSES(16), .BUS_ID_WIDTH(4), .WB_ADDR_WIDTH(2),
    .WB_DATA_WIDTH(8), .IRQ_TIMEOUT(TO_CYC)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_rw_i(req_rw_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o), .rsp_rdata_o(rsp_rdata_o),
    .busy_o(busy_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Wishbone access log {we, adr, dat} (reads logged with dat 0) and the model's expectation.
  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];

  // iicmb + I2C slave behavioural model state.
  int         cyc_cnt = 0, rsp_cnt = 0, viol = 0, start_cyc = 0, t_rsp = 0;
  int         wait_cnt = 0, irq_dly = 0;
  bit         irq_pend = 0, expect_addr = 0;
  logic [7:0] dpr_q = 0, dpr_rd = 0, cmdr_stat = 0, slave_rx = 0, slave_tx = 0;
  logic [7:0] al_cmd = 8'hFF, sup_cmd = 8'hFF;
  logic [7:0] exp_rdata = 8'h00;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slaves answer for addresses 0x20..0x3F; everything else NAKs.
  function automatic bit present(input logic [6:0] a);
    return a[6:5] == 2'b01;
  endfunction

  task automatic core_cmd(input logic [7:0] c);
    logic [7:0] stat;
    bit nak;
    nak  = 1'b0;
    stat = 8'h80;
    case (c)
      8'h04: begin expect_addr = 1'b1; start_cyc = cyc_cnt; end
      8'h01: begin
        if (expect_addr) begin
          expect_addr = 1'b0;
          nak = !present(dpr_q[7:1]);
        end else slave_rx = dpr_q;
      end
      8'h03: dpr_rd = slave_tx;
      default: ;
    endcase
    if (nak) stat = 8'h40 | (8'($urandom_range(0, 1)) << 7);
    if (c == al_cmd) stat = 8'hA0;
    cmdr_stat = stat;
    if (c != sup_cmd) begin
      irq_pend = 1'b1;
      irq_dly  = $urandom_range(0, 3);
    end
  endtask

  task automatic wb_access();
    if (we_o) begin
      log_q.push_back({1'b1, adr_o, dat_o});
      if (adr_o == 2'd1) dpr_q = dat_o;
      else if (adr_o == 2'd2) core_cmd(dat_o);
    end else begin
      log_q.push_back({1'b0, adr_o, 8'h00});
      case (adr_o)
        2'd2: begin dat_i = cmdr_stat; irq_i = 1'b0; end
        2'd1: dat_i = dpr_rd;
        default: dat_i = 8'h00;
      endcase
    end
  endtask

  // Responder and protocol monitor, updated on the falling edge.
  initial begin
    ack_i = 1'b0; irq_i = 1'b0; dat_i = 8'h00;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (rsp_valid_o) rsp_cnt++;
      if (ack_i && cyc_o) viol++;
      if (cyc_o !== stb_o) viol++;
      if (!rst_n_i) begin
        ack_i = 1'b0; irq_i = 1'b0; irq_pend = 1'b0; wait_cnt = 0;
        dat_i = 8'h00; expect_addr = 1'b0;
      end else begin
        if (cyc_o && !ack_i) begin
          if (wait_cnt == 0) begin
            ack_i = 1'b1;
            wb_access();
            wait_cnt = $urandom_range(0, 2);
          end else wait_cnt--;
        end else ack_i = 1'b0;
        if (irq_pend) begin
          if (irq_dly == 0) begin irq_i = 1'b1; irq_pend = 1'b0; end
          else irq_dly--;
        end
      end
    end
  end

  // Reference: 0 done, 1 NAK, 2 AL/ERR, 3 no irq.
  function automatic int outcome(input logic [7:0] c, input bit is_addr, input logic [6:0] a);
    if (c == sup_cmd) return 3;
    if (c == al_cmd) return 2;
    if (is_addr && !present(a)) return 1;
    return 0;
  endfunction

  task automatic mcmd(input logic [7:0] c, input bit is_addr, input logic [6:0] a, output int o);
    exp_q.push_back({1'b1, 2'd2, c});
    o = outcome(c, is_addr, a);
    if (o == 3) begin
      exp_q.push_back({1'b1, 2'd0, 8'h00});
      exp_q.push_back({1'b1, 2'd0, 8'hC0});
    end else exp_q.push_back({1'b0, 2'd2, 8'h00});
  endtask

  task automatic build_expect(input bit rw, input logic [3:0] bus, input logic [6:0] addr,
                              input logic [7:0] wd, output logic [1:0] st);
    int o;
    bit fin, nak;
    exp_q.delete();
    st = 2'b00; fin = 0; nak = 0;
    exp_q.push_back({1'b1, 2'd1, 4'h0, bus});
    mcmd(8'h06, 0, addr, o);
    if (o >= 2) begin st = 2'(o); fin = 1; end
    if (!fin) begin
      mcmd(8'h04, 0, addr, o);
      if (o >= 2) begin st = 2'(o); fin = 1; end
    end
    if (!fin) begin
      exp_q.push_back({1'b1, 2'd1, addr, rw});
      mcmd(8'h01, 1, addr, o);
      if (o >= 2) begin st = 2'(o); fin = 1; end
      else if (o == 1) begin st = 2'b01; nak = 1; end
    end
    if (!fin && !nak) begin
      if (!rw) begin
        exp_q.push_back({1'b1, 2'd1, wd});
        mcmd(8'h01, 0, addr, o);
      end else begin
        mcmd(8'h03, 0, addr, o);
        if (o < 2) exp_q.push_back({1'b0, 2'd1, 8'h00});
      end
      if (o >= 2) begin st = 2'(o); fin = 1; end
    end
    if (!fin) begin
      mcmd(8'h05, 0, addr, o);
      if (o >= 2) st = 2'(o);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready_o && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready_o) chk(0, 1, {tag, "_ready_timeout"});
  endtask

  task automatic run_txn(input bit rw, input logic [3:0] bus, input logic [6:0] addr,
                         input logic [7:0] wd, input logic [7:0] al, input logic [7:0] sup,
                         input string tag);
    logic [1:0] est;
    logic [7:0] erd;
    int n;
    al_cmd = al; sup_cmd = sup;
    slave_tx = 8'($urandom_range(0, 255));
    build_expect(rw, bus, addr, wd, est);
    erd = (est == 2'b00 && rw) ? slave_tx : exp_rdata;
    wait_ready(tag);
    log_q.delete();
    req_bus_i = bus; req_addr_i = addr; req_rw_i = rw; req_wdata_i = wd;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk({busy_o, req_ready_o}, 2'b10, {tag, "_accept"});
    n = 0;
    while (!rsp_valid_o && n < 5000) begin @(negedge clk); n++; end
    t_rsp = cyc_cnt;
    chk(rsp_valid_o, 1, {tag, "_rsp_seen"});
    chk(rsp_status_o, est, {tag, "_status"});
    chk(rsp_rdata_o, erd, {tag, "_rdata"});
    chk(log_q.size(), exp_q.size(), {tag, "_wb_len"});
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(log_q[i], exp_q[i], $sformatf("%s_wb%0d", tag, i));
    if (!rw && est == 2'b00) chk(slave_rx, wd, {tag, "_slave_rx"});
    @(negedge clk);
    chk({rsp_valid_o, req_ready_o, busy_o}, 3'b010, {tag, "_back_idle"});
    exp_rdata = erd;
  endtask

  logic [7:0] cmds[5] = '{8'h06, 8'h04, 8'h01, 8'h03, 8'h05};

  initial begin
    int n, rc0;
    logic [7:0] al, sup;
    logic [6:0] a;
    rst_n_i = 1'b0; req_valid_i = 1'b0; req_bus_i = '0; req_addr_i = '0;
    req_rw_i = 1'b0; req_wdata_i = '0;
    repeat (3) @(negedge clk);
    chk({cyc_o, stb_o, we_o, adr_o, dat_o}, 0, "reset_wb");
    chk({req_ready_o, rsp_valid_o, busy_o, rsp_status_o, rsp_rdata_o}, 0, "reset_ctl");
    log_q.delete();
    rst_n_i = 1'b1;
    wait_ready("init");
    chk(log_q.size(), 1, "init_len");
    chk(log_q.size() > 0 ? log_q[0] : 11'h0, {1'b1, 2'd0, 8'hC0}, "init_csr");

    run_txn(0, 4'd2, 7'h22, 8'hA5, 8'hFF, 8'hFF, "wr");
    run_txn(1, 4'd0, 7'h22, 8'h00, 8'hFF, 8'hFF, "rd");
    run_txn(1, 4'd1, 7'h10, 8'h00, 8'hFF, 8'hFF, "nak");
    run_txn(0, 4'd3, 7'h22, 8'h3C, 8'hFF, 8'h04, "timeout");
    chk((t_rsp - start_cyc) >= TO_CYC && (t_rsp - start_cyc) <= TO_CYC + 15, 1, "timeout_lat");
    run_txn(0, 4'd3, 7'h22, 8'h3C, 8'hFF, 8'hFF, "after_to");
    run_txn(1, 4'd15, 7'h30, 8'h00, 8'h06, 8'hFF, "al_setbus");

    for (int k = 0; k < 14; k++) begin
      a = ($urandom_range(0, 3) != 0) ? (7'h20 | 7'($urandom_range(0, 31)))
                                      : 7'($urandom_range(0, 127));
      al  = ($urandom_range(0, 9) < 7) ? 8'hFF : cmds[$urandom_range(0, 4)];
      sup = ($urandom_range(0, 9) != 0) ? 8'hFF : cmds[$urandom_range(0, 4)];
      run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a,
              8'($urandom_range(0, 255)), al, sup, $sformatf("rnd%0d", k));
    end

    // Reset in the middle of the data phase of a write.
    al_cmd = 8'hFF; sup_cmd = 8'hFF;
    wait_ready("mid");
    log_q.delete();
    rc0 = rsp_cnt;
    req_bus_i = 4'd2; req_addr_i = 7'h22; req_rw_i = 1'b0; req_wdata_i = 8'h77;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0;
    while (log_q.size() < 9 && n < 2000) begin @(negedge clk); n++; end
    chk(log_q.size() >= 9, 1, "mid_reached_data");
    rst_n_i = 1'b0;
    @(negedge clk);
    chk({cyc_o, stb_o, busy_o, rsp_valid_o, req_ready_o}, 0, "mid_reset_ctl");
    chk({rsp_status_o, rsp_rdata_o}, 0, "mid_reset_rsp");
    @(negedge clk);
    log_q.delete();
    rst_n_i = 1'b1;
    exp_rdata = 8'h00;
    wait_ready("mid_init");
    chk(log_q.size(), 1, "mid_init_len");
    chk(log_q.size() > 0 ? log_q[0] : 11'h0, {1'b1, 2'd0, 8'hC0}, "mid_init_csr");
    repeat (5) @(negedge clk);
    chk(rsp_cnt, rc0, "mid_no_rsp");
    run_txn(1, 4'd4, 7'h2A, 8'h00, 8'hFF, 8'hFF, "post_reset");

    chk(viol, 0, "wb_protocol");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
